// File: rtl/generation_scheduler.sv
// generation_scheduler: sequences one neuroevolution run. Each generation
// starts the shared evaluator once per genome, then selection, then mutation,
// using the start/finished handshake. A stop request lets the running
// handshake finish, skips the remaining evaluations, still runs select and
// mutate, then ends the run.
module generation_scheduler #(
    parameter int POP_SIZE  = 16,
    parameter int IDX_WIDTH = 4,
    parameter int GEN_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [GEN_WIDTH-1:0] max_gen,
    output logic                 finished,
    output logic [GEN_WIDTH-1:0] gen_count,
    output logic                 eval_start,
    output logic [IDX_WIDTH-1:0] eval_index,
    input  logic                 eval_finished,
    output logic                 select_start,
    input  logic                 select_finished,
    output logic                 mutate_start,
    input  logic                 mutate_finished
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        EV_START  = 4'd1,
        EV_DELAY  = 4'd2,
        EV_WAIT   = 4'd3,
        SEL_START = 4'd4,
        SEL_DELAY = 4'd5,
        SEL_WAIT  = 4'd6,
        MUT_START = 4'd7,
        MUT_DELAY = 4'd8,
        MUT_WAIT  = 4'd9,
        DONE      = 4'd10
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_INDEX = IDX_WIDTH'(POP_SIZE - 1);

    state_t               state_r, state_s;
    logic [IDX_WIDTH-1:0] eval_index_r, eval_index_s;
    logic [GEN_WIDTH-1:0] gen_count_r, gen_count_s;
    logic [GEN_WIDTH-1:0] max_gen_r, max_gen_s;
    logic                 abort_r, abort_s;
    logic                 abort_pending_s;
    logic [GEN_WIDTH-1:0] gen_inc_s;

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r      <= IDLE;
            eval_index_r <= {IDX_WIDTH{1'b0}};
            gen_count_r  <= {GEN_WIDTH{1'b0}};
            max_gen_r    <= {GEN_WIDTH{1'b0}};
            abort_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            eval_index_r <= eval_index_s;
            gen_count_r  <= gen_count_s;
            max_gen_r    <= max_gen_s;
            abort_r      <= abort_s;
        end
    end

    // Next-state and datapath update; a stop seen this cycle counts as pending
    always_comb begin
        state_s         = state_r;
        eval_index_s    = eval_index_r;
        gen_count_s     = gen_count_r;
        max_gen_s       = max_gen_r;
        abort_s         = abort_r;
        gen_inc_s       = gen_count_r + GEN_WIDTH'(1);
        abort_pending_s = abort_r | stop;

        if (state_r != IDLE) begin
            abort_s = abort_pending_s;
        end else begin
            abort_s = 1'b0;
        end

        case (state_r)
            IDLE: begin
                if (start) begin
                    gen_count_s  = {GEN_WIDTH{1'b0}};
                    eval_index_s = {IDX_WIDTH{1'b0}};
                    max_gen_s    = max_gen;
                    if (max_gen == {GEN_WIDTH{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = EV_START;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EV_START:  state_s = EV_DELAY;
            EV_DELAY:  state_s = EV_WAIT;
            EV_WAIT: begin
                if (eval_finished) begin
                    if ((eval_index_r == LAST_INDEX) || abort_pending_s) begin
                        state_s = SEL_START;
                    end else begin
                        eval_index_s = eval_index_r + IDX_WIDTH'(1);
                        state_s      = EV_START;
                    end
                end else begin
                    state_s = EV_WAIT;
                end
            end
            SEL_START: state_s = SEL_DELAY;
            SEL_DELAY: state_s = SEL_WAIT;
            SEL_WAIT: begin
                if (select_finished) begin
                    state_s = MUT_START;
                end else begin
                    state_s = SEL_WAIT;
                end
            end
            MUT_START: state_s = MUT_DELAY;
            MUT_DELAY: state_s = MUT_WAIT;
            MUT_WAIT: begin
                if (mutate_finished) begin
                    gen_count_s = gen_inc_s;
                    if ((gen_inc_s == max_gen_r) || abort_pending_s) begin
                        state_s = DONE;
                    end else begin
                        eval_index_s = {IDX_WIDTH{1'b0}};
                        state_s      = EV_START;
                    end
                end else begin
                    state_s = MUT_WAIT;
                end
            end
            DONE:      state_s = IDLE;
            default:   state_s = IDLE;
        endcase
    end

    // Outputs decoded purely from registered state
    always_comb begin
        finished     = (state_r == IDLE);
        eval_start   = (state_r == EV_START)  || (state_r == EV_DELAY);
        select_start = (state_r == SEL_START) || (state_r == SEL_DELAY);
        mutate_start = (state_r == MUT_START) || (state_r == MUT_DELAY);
        gen_count    = gen_count_r;
        eval_index   = eval_index_r;
    end

endmodule

// File: tb/tb_generation_scheduler.sv
// Directed testbench for generation_scheduler with POP_SIZE=4. Sub-unit
// models drop finished when they see start and raise it again a programmable
// number of cycles after the scheduler enters WAIT.
module tb_generation_scheduler;

    localparam int POP = 4;
    localparam int IW  = 2;
    localparam int GW  = 8;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [GW-1:0] max_gen = 8'd0;
    logic          finished;
    logic [GW-1:0] gen_count;
    logic          eval_start, select_start, mutate_start;
    logic [IW-1:0] eval_index;
    logic          eval_finished, select_finished, mutate_finished;

    int sub_delay = 0;
    int tests = 0;
    int fails = 0;

    generation_scheduler #(.POP_SIZE(POP), .IDX_WIDTH(IW), .GEN_WIDTH(GW)) dut (
        .clock(clock), .resetn(resetn), .start(start), .stop(stop),
        .max_gen(max_gen), .finished(finished), .gen_count(gen_count),
        .eval_start(eval_start), .eval_index(eval_index),
        .eval_finished(eval_finished), .select_start(select_start),
        .select_finished(select_finished), .mutate_start(mutate_start),
        .mutate_finished(mutate_finished)
    );

    always #5 clock = ~clock;

    // Sub-unit models: accept a job when start is seen while finished
    int ev_cnt_d, sel_cnt_d, mut_cnt_d;
    always @(posedge clock) begin
        if (!resetn) begin
            eval_finished <= 1'b1; select_finished <= 1'b1; mutate_finished <= 1'b1;
            ev_cnt_d <= 0; sel_cnt_d <= 0; mut_cnt_d <= 0;
        end else begin
            if (eval_start && eval_finished) begin
                eval_finished <= 1'b0; ev_cnt_d <= sub_delay;
            end else if (!eval_finished) begin
                if (ev_cnt_d == 0) eval_finished <= 1'b1; else ev_cnt_d <= ev_cnt_d - 1;
            end
            if (select_start && select_finished) begin
                select_finished <= 1'b0; sel_cnt_d <= sub_delay;
            end else if (!select_finished) begin
                if (sel_cnt_d == 0) select_finished <= 1'b1; else sel_cnt_d <= sel_cnt_d - 1;
            end
            if (mutate_start && mutate_finished) begin
                mutate_finished <= 1'b0; mut_cnt_d <= sub_delay;
            end else if (!mutate_finished) begin
                if (mut_cnt_d == 0) mutate_finished <= 1'b1; else mut_cnt_d <= mut_cnt_d - 1;
            end
        end
    end

    // Pulse monitor: counts start pulses, logs eval indices, checks pulse shape
    int            ev_pulses = 0, sel_pulses = 0, mut_pulses = 0;
    int            start_cycles = 0, bad_len = 0, bad_hold = 0, ev_len = 0;
    logic          ev_prev = 1'b0, sel_prev = 1'b0, mut_prev = 1'b0;
    logic [IW-1:0] ev_hold = '0;
    logic [IW-1:0] idx_log [0:63];
    always @(negedge clock) begin
        if (eval_start && !ev_prev) begin
            if (ev_pulses < 64) idx_log[ev_pulses] = eval_index;
            ev_pulses = ev_pulses + 1;
            ev_len = 1;
            ev_hold = eval_index;
        end else if (eval_start) begin
            ev_len = ev_len + 1;
            if (eval_index != ev_hold) bad_hold = bad_hold + 1;
        end
        if (!eval_start && ev_prev && ev_len != 2) bad_len = bad_len + 1;
        if (select_start && !sel_prev) sel_pulses = sel_pulses + 1;
        if (mutate_start && !mut_prev) mut_pulses = mut_pulses + 1;
        if (eval_start || select_start || mutate_start) start_cycles = start_cycles + 1;
        ev_prev = eval_start; sel_prev = select_start; mut_prev = mutate_start;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        if (obs !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then count cycles until finished returns
    task automatic run(input logic [GW-1:0] mg, output int low_cycles);
        @(negedge clock);
        max_gen = mg; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        low_cycles = 0;
        while (!finished && low_cycles < 2000) begin
            low_cycles = low_cycles + 1;
            @(negedge clock);
        end
        check_eq("run_terminates", {31'd0, finished}, 32'd1);
    endtask

    int low, b_ev, b_sel, b_mut, b_st, b_len, b_hold, guard;

    initial begin
        // Reset values
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst_finished", {31'd0, finished}, 32'd1);
        check_eq("rst_gen_count", {24'd0, gen_count}, 32'd0);
        check_eq("rst_eval_index", {30'd0, eval_index}, 32'd0);
        check_eq("rst_starts", {29'd0, eval_start, select_start, mutate_start}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // Normal run: 2 generations, sub-units finish 3 cycles into WAIT
        sub_delay = 3;
        b_ev = ev_pulses; b_sel = sel_pulses; b_mut = mut_pulses; b_len = bad_len; b_hold = bad_hold;
        run(8'd2, low);
        check_eq("norm_low_cycles", low, 32'd73);
        check_eq("norm_eval_pulses", ev_pulses - b_ev, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("norm_idx%0d", i), {30'd0, idx_log[b_ev + i]}, i % POP);
        end
        check_eq("norm_pulse_len", bad_len - b_len, 32'd0);
        check_eq("norm_idx_stable", bad_hold - b_hold, 32'd0);
        check_eq("norm_sel_pulses", sel_pulses - b_sel, 32'd2);
        check_eq("norm_mut_pulses", mut_pulses - b_mut, 32'd2);
        check_eq("norm_gen_count", {24'd0, gen_count}, 32'd2);

        // Zero-delay sub-units: one generation is 18 cycles plus DONE
        sub_delay = 0;
        run(8'd1, low);
        check_eq("zero_low_cycles", low, 32'd19);
        check_eq("zero_gen_count", {24'd0, gen_count}, 32'd1);

        // max_gen = 0: straight to DONE, no sub-unit started
        b_st = start_cycles;
        run(8'd0, low);
        check_eq("mg0_low_cycles", low, 32'd1);
        check_eq("mg0_no_starts", start_cycles - b_st, 32'd0);
        check_eq("mg0_gen_count", {24'd0, gen_count}, 32'd0);

        // Abort during EV_WAIT of index 1
        sub_delay = 3;
        b_ev = ev_pulses; b_sel = sel_pulses; b_mut = mut_pulses;
        @(negedge clock);
        max_gen = 8'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        guard = 0;
        while (!(eval_index == 2'd1 && !eval_start && !finished) && guard < 200) begin
            guard = guard + 1;
            @(negedge clock);
        end
        check_eq("abort_reach_wait1", {31'd0, guard < 200}, 32'd1);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        low = 0;
        while (!finished && low < 2000) begin
            low = low + 1;
            @(negedge clock);
        end
        check_eq("abort_finished", {31'd0, finished}, 32'd1);
        check_eq("abort_eval_pulses", ev_pulses - b_ev, 32'd2);
        check_eq("abort_last_idx", {30'd0, idx_log[b_ev + 1]}, 32'd1);
        check_eq("abort_sel_pulses", sel_pulses - b_sel, 32'd1);
        check_eq("abort_mut_pulses", mut_pulses - b_mut, 32'd1);
        check_eq("abort_gen_count", {24'd0, gen_count}, 32'd1);

        // Start while busy: max_gen and eval_index untouched
        @(negedge clock);
        max_gen = 8'd2; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        guard = 0;
        while (!(eval_index == 2'd2 && !eval_start && !finished) && guard < 200) begin
            guard = guard + 1;
            @(negedge clock);
        end
        check_eq("busy_reach_wait2", {31'd0, guard < 200}, 32'd1);
        max_gen = 8'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_eq("busy_idx_kept", {30'd0, eval_index}, 32'd2);
        check_eq("busy_still_running", {31'd0, finished}, 32'd0);
        low = 0;
        while (!finished && low < 2000) begin
            low = low + 1;
            @(negedge clock);
        end
        check_eq("busy_gen_count", {24'd0, gen_count}, 32'd2);
        max_gen = 8'd0;

        // Mid-run reset during SEL_DELAY
        @(negedge clock);
        max_gen = 8'd2; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        guard = 0;
        while (!select_start && guard < 200) begin
            guard = guard + 1;
            @(negedge clock);
        end
        check_eq("rst_reach_sel", {31'd0, select_start}, 32'd1);
        @(negedge clock);
        check_eq("rst_in_sel_delay", {31'd0, select_start}, 32'd1);
        resetn = 1'b0;
        @(negedge clock);
        check_eq("midrst_sel_start", {31'd0, select_start}, 32'd0);
        check_eq("midrst_finished", {31'd0, finished}, 32'd1);
        check_eq("midrst_gen_count", {24'd0, gen_count}, 32'd0);
        check_eq("midrst_eval_index", {30'd0, eval_index}, 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("midrst_stays_idle", {31'd0, finished}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
